// File: rtl/col_sense_ctrl.sv
// Column sense sequencer: precharge, sense and result capture
// for row read, CAM search and 4-row MAC popcount sweep.
module col_sense_ctrl #(
    parameter int unsigned PRE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] addr,
    input  logic [3:0] SA_out,
    output logic       PRE,
    output logic       SAE,
    output logic [1:0] row_sel,
    output logic       busy,
    output logic       valid,
    output logic [3:0] rdata,
    output logic       hit,
    output logic [1:0] hit_addr,
    output logic [4:0] mac_sum
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_SENSE,
        ST_DONE
    } state_t;

    localparam logic [1:0] M_READ = 2'b00;
    localparam logic [1:0] M_CAM  = 2'b01;
    localparam logic [1:0] M_MAC  = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;

    localparam logic [3:0] PRE_LD = 4'(PRE_CYC);

    state_t     state;
    logic [1:0] mode_q;
    logic [3:0] pre_cnt;
    logic [1:0] row_cnt;
    logic [4:0] acc;

    logic [2:0] sa_pop;
    logic [4:0] acc_next;
    logic       sa_any;
    logic [1:0] sa_low;

    // Popcount and lowest-set-index of the sense-amp word.
    always_comb begin
        sa_pop = 3'd0;
        for (int i = 0; i < 4; i++) begin
            sa_pop = sa_pop + {2'b00, SA_out[i]};
        end
        acc_next = acc + {2'b00, sa_pop};
        sa_any   = |SA_out;
        sa_low   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (SA_out[i]) begin
                sa_low = 2'(i);
            end
        end
    end

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= M_READ;
            pre_cnt  <= 4'd0;
            row_cnt  <= 2'd0;
            acc      <= 5'd0;
            PRE      <= 1'b0;
            SAE      <= 1'b0;
            row_sel  <= 2'd0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            rdata    <= 4'd0;
            hit      <= 1'b0;
            hit_addr <= 2'd0;
            mac_sum  <= 5'd0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && mode != M_RSV) begin
                        mode_q  <= mode;
                        pre_cnt <= PRE_LD;
                        row_cnt <= 2'd0;
                        acc     <= 5'd0;
                        row_sel <= (mode == M_READ) ? addr : 2'd0;
                        PRE     <= 1'b1;
                        SAE     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    pre_cnt <= pre_cnt - 4'd1;
                    if (pre_cnt == 4'd1) begin
                        PRE   <= 1'b0;
                        SAE   <= 1'b1;
                        state <= ST_SENSE;
                    end
                end
                ST_SENSE: begin
                    SAE   <= 1'b0;
                    state <= ST_DONE;
                    case (mode_q)
                        M_READ: rdata <= SA_out;
                        M_CAM: begin
                            hit      <= sa_any;
                            hit_addr <= sa_low;
                        end
                        M_MAC: begin
                            acc <= acc_next;
                            if (row_cnt == 2'd3) begin
                                mac_sum <= acc_next;
                            end else begin
                                row_cnt <= row_cnt + 2'd1;
                                row_sel <= row_cnt + 2'd1;
                                pre_cnt <= PRE_LD;
                                PRE     <= 1'b1;
                                state   <= ST_PRE;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_col_sense_ctrl.sv
// Randomized bench for col_sense_ctrl against a timeline and
// result model derived from the operation rules.
module tb_col_sense_ctrl;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] addr = 2'b00;
    logic [3:0] SA_out = 4'h0;
    logic       PRE, SAE, busy, valid, hit;
    logic [1:0] row_sel, hit_addr;
    logic [3:0] rdata;
    logic [4:0] mac_sum;

    int checks = 0;
    int errors = 0;

    logic [3:0] sa_hist [0:63];
    logic [3:0] exp_rdata;
    logic       exp_hit;
    logic [1:0] exp_hit_addr;
    logic [4:0] exp_mac;

    col_sense_ctrl #(.PRE_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mode(mode), .addr(addr), .SA_out(SA_out),
        .PRE(PRE), .SAE(SAE), .row_sel(row_sel),
        .busy(busy), .valid(valid), .rdata(rdata),
        .hit(hit), .hit_addr(hit_addr), .mac_sum(mac_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_PRE"}, 32'(PRE), 0);
        check({tag, "_SAE"}, 32'(SAE), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_hit"}, 32'(hit), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_hitaddr"}, 32'(hit_addr), 0);
        check({tag, "_rowsel"}, 32'(row_sel), 0);
        check({tag, "_mac"}, 32'(mac_sum), 0);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_hitaddr"}, 32'(hit_addr), 32'(exp_hit_addr));
        check({tag, "_mac"}, 32'(mac_sum), 32'(exp_mac));
    endtask

    task automatic update_model(input logic [1:0] m);
        logic [3:0] v;
        int         s;
        if (m == 2'd2) begin
            s = 0;
            for (int r = 0; r < 4; r++) begin
                s += $countones(sa_hist[(r + 1) * (P + 1)]);
            end
            exp_mac = 5'(s);
        end else begin
            v = sa_hist[P + 1];
            if (m == 2'd0) begin
                exp_rdata = v;
            end else begin
                exp_hit = |v;
                exp_hit_addr = 2'd0;
                for (int i = 3; i >= 0; i--) begin
                    if (v[i]) exp_hit_addr = 2'(i);
                end
            end
        end
    endtask

    // abort_at >= 0 applies reset at that point of the timeline.
    task automatic run_op(input logic [1:0] m,
                          input logic [1:0] a,
                          input bit fix_en,
                          input logic [15:0] fix,
                          input bit noise,
                          input int abort_at);
        int L, ph, row, idx;
        bit in_pre, in_sae;
        logic [3:0] v;
        logic [1:0] exp_row;
        L = (m == 2'd2) ? 4 * (P + 1) + 1 : P + 2;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        addr = a;
        SA_out = 4'($urandom);
        for (int n = 0; n <= L; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                exp_rdata = 0;
                exp_hit = 0;
                exp_hit_addr = 0;
                exp_mac = 0;
                check_zero("abort");
                repeat (2) begin
                    @(negedge clk);
                    check("abort_valid", 32'(valid), 0);
                end
                rst_n = 1'b1;
                return;
            end
            ph = n % (P + 1);
            row = n / (P + 1);
            in_pre = (n < L - 1) && (ph < P);
            in_sae = (n < L - 1) && (ph == P);
            check("PRE", 32'(PRE), 32'(in_pre));
            check("SAE", 32'(SAE), 32'(in_sae));
            check("busy", 32'(busy), 32'(n < L));
            check("valid", 32'(valid), 32'(n == L));
            if (in_pre || in_sae) begin
                exp_row = (m == 2'd2) ? 2'(row)
                        : (m == 2'd0) ? a : 2'd0;
                check("row_sel", 32'(row_sel), 32'(exp_row));
            end
            if (n == L) begin
                update_model(m);
                check_results("res");
            end
            start = (noise && n < L) ? 1'($urandom) : 1'b0;
            mode = noise ? 2'($urandom) : m;
            addr = noise ? 2'($urandom) : a;
            v = 4'($urandom);
            if (fix_en && ((n + 1) % (P + 1) == 0)) begin
                idx = (n + 1) / (P + 1) - 1;
                if (idx >= 0 && idx < 4) v = fix[4 * idx +: 4];
            end
            SA_out = v;
            sa_hist[n + 1] = v;
        end
        start = 1'b0;
    endtask

    initial begin
        exp_rdata = 0;
        exp_hit = 0;
        exp_hit_addr = 0;
        exp_mac = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 2'd2, 1'b1, 16'h000B, 1'b0, -1);
        check("read_1011", 32'(rdata), 32'hB);
        run_op(2'd1, 2'd3, 1'b1, 16'h0006, 1'b0, -1);
        check("cam_hit", 32'(hit), 1);
        check("cam_idx", 32'(hit_addr), 1);
        run_op(2'd1, 2'd0, 1'b1, 16'h0000, 1'b0, -1);
        check("cam_miss", 32'(hit), 0);
        check("cam_idx0", 32'(hit_addr), 0);
        run_op(2'd2, 2'd1, 1'b1, 16'h701F, 1'b1, -1);
        check("mac_8", 32'(mac_sum), 8);
        run_op(2'd2, 2'd0, 1'b1, 16'hFFFF, 1'b0, -1);
        check("mac_16", 32'(mac_sum), 16);

        @(negedge clk);
        start = 1'b1;
        mode = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("rsv_busy", 32'(busy), 0);
            check("rsv_valid", 32'(valid), 0);
            check("rsv_PRE", 32'(PRE), 0);
        end
        start = 1'b0;
        check_results("rsv_hold");

        run_op(2'd2, 2'd0, 1'b0, 16'h0, 1'b0, 2 * P + 1);
        run_op(2'd0, 2'd1, 1'b0, 16'h0, 1'b0, -1);

        for (int k = 0; k < 30; k++) begin
            run_op(2'($urandom_range(0, 2)), 2'($urandom),
                   1'b0, 16'h0, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
